// File: rtl/bidir_pio_bank.sv
// Avalon-MM bidirectional PIO bank: per-bit direction, synchronised pin readback, atomic set/clear.
// Define BIDIR_PIO_EDGE_IRQ_EN to add edge capture, the post-reset warm-up counter and a maskable irq.
module bidir_pio_bank #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter logic [31:0] RESET_OUT   = '0,
  parameter logic [31:0] RESET_DIR   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  inout  wire  [WIDTH-1:0] bidir_port,
  output logic             irq
);

  typedef enum logic [2:0] {
    A_DATA = 3'd0,
    A_DIR  = 3'd1,
    A_MASK = 3'd2,
    A_EDGE = 3'd3,
    A_SET  = 3'd4,
    A_CLR  = 3'd5
  } addr_e;

  localparam logic [WIDTH-1:0] OUT_RST = {WIDTH{RESET_OUT[0]}};
  localparam logic [WIDTH-1:0] DIR_RST = RESET_DIR[WIDTH-1:0];

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;

  assign wr       = chipselect & ~write_n;
  assign wd       = writedata[WIDTH-1:0];
  assign sync_out = sync_q[SYNC_STAGES-1];
  assign readdata = rdata_q;

  if (WIDTH < 32) begin : g_unused_wd
    logic unused_wd;
    assign unused_wd = ^writedata[31:WIDTH];
  end

  // The direction flop resets asynchronously, so pins float the moment reset asserts.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  // NOTE: combinational blocks use blocking '=' with every output defaulted first (no latches);
  // clocked blocks use non-blocking '<=' only, so all flops sample pre-edge values.
  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    if (wr) begin
      case (address)
        A_DATA:  out_d = wd;
        A_DIR:   dir_d = wd;
        A_SET:   out_d = out_q | wd;
        A_CLR:   out_d = out_q & ~wd;
        default: ;
      endcase
    end
  end

  always_comb begin
    sync_d[0] = bidir_port;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

`ifdef BIDIR_PIO_EDGE_IRQ_EN
  localparam logic [2:0] WARM_CYCLES = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] rise, fall, edge_det;
  logic [2:0]       warm_q, warm_d;
  logic             warm_done;
  logic             irq_q, irq_d;

  // The chain fills from zero after reset; without the warm-up a pin held high would look like a rise.
  always_comb begin
    prev_d    = sync_out;
    warm_done = (warm_q == WARM_CYCLES);
    warm_d    = warm_done ? warm_q : warm_q + 3'd1;
    rise      = sync_out & ~prev_q;
    fall      = ~sync_out & prev_q;
    if (EDGE_TYPE == 0)      edge_det = rise;
    else if (EDGE_TYPE == 1) edge_det = fall;
    else                     edge_det = rise | fall;
    if (!warm_done) edge_det = '0;

    mask_d = (wr && address == A_MASK) ? wd : mask_q;

    edge_cap_d = edge_cap_q;
    if (wr && address == A_EDGE) edge_cap_d = edge_cap_q & ~wd;
    edge_cap_d = edge_cap_d | edge_det;
    irq_d      = |(edge_cap_q & mask_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q     <= '0;
      mask_q     <= '0;
      edge_cap_q <= '0;
      warm_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      mask_q     <= mask_d;
      edge_cap_q <= edge_cap_d;
      warm_q     <= warm_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^EDGE_TYPE;
  assign irq        = 1'b0;
`endif

  always_comb begin
    rdata_d = '0;
    case (address)
      A_DATA:  rdata_d[WIDTH-1:0] = sync_out;
      A_DIR:   rdata_d[WIDTH-1:0] = dir_q;
`ifdef BIDIR_PIO_EDGE_IRQ_EN
      A_MASK:  rdata_d[WIDTH-1:0] = mask_q;
      A_EDGE:  rdata_d[WIDTH-1:0] = edge_cap_q;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= OUT_RST;
      dir_q   <= DIR_RST;
      rdata_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

endmodule

// File: tb/tb_bidir_pio_bank.sv
// Directed bench for bidir_pio_bank (WIDTH=8, SYNC_STAGES=2, EDGE_TYPE=0, reset values 0).
// Edge/irq steps run when BIDIR_PIO_EDGE_IRQ_EN is defined; otherwise the disabled map is checked.
module tb_bidir_pio_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  wire  [7:0]  pins;

  logic [7:0]  tb_oe;
  logic [7:0]  tb_val;
  logic [31:0] rd_val;

  int tests = 0;
  int fails = 0;

  for (genvar i = 0; i < 8; i++) begin : g_drv
    assign pins[i] = tb_oe[i] ? tb_val[i] : 1'bz;
  end

  bidir_pio_bank #(
    .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_OUT(32'h0), .RESET_DIR(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .bidir_port(pins), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  initial begin
    reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    tb_oe = 8'hFF; tb_val = 8'h00;

    // T1: reset state
    ticks(3);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    rd(3'd1, rd_val); check("rst_dir", rd_val, 32'h0);
    rd(3'd0, rd_val); check("rst_pins_read", rd_val, 32'h0);

    // T2: drive all pins
    tb_oe = 8'h00;
    wr(3'd1, 32'hFF);
    wr(3'd0, 32'hA5);
    check("drive_pins", {24'h0, pins}, 32'hA5);
    ticks(3);
    check("drive_readback", readdata, 32'hA5);
    rd(3'd1, rd_val); check("dir_read", rd_val, 32'hFF);

    // T3: atomic set / clear
    wr(3'd0, 32'h0F);
    wr(3'd4, 32'h30);
    check("set_pins", {24'h0, pins}, 32'h3F);
    rd(3'd4, rd_val); check("set_reads0", rd_val, 32'h0);
    wr(3'd5, 32'h03);
    check("clr_pins", {24'h0, pins}, 32'h3C);
    rd(3'd5, rd_val); check("clr_reads0", rd_val, 32'h0);
    address = 3'd0; ticks(3);
    check("clr_readback", readdata, 32'h3C);

    // data_out written while pins are inputs stays off the pins
    wr(3'd1, 32'h00);
    tb_oe = 8'hFF; tb_val = 8'h96;
    wr(3'd0, 32'h11);
    check("in_pins", {24'h0, pins}, 32'h96);
    address = 3'd0; ticks(3);
    check("in_readback", readdata, 32'h96);
    tb_oe = 8'h00;
    wr(3'd1, 32'hFF);
    check("stored_out", {24'h0, pins}, 32'h11);

    // reserved addresses
    wr(3'd6, 32'hFF);
    wr(3'd7, 32'h00);
    check("rsvd_nowrite", {24'h0, pins}, 32'h11);
    rd(3'd6, rd_val); check("rsvd6_read", rd_val, 32'h0);
    rd(3'd7, rd_val); check("rsvd7_read", rd_val, 32'h0);

    // back to inputs, tb drives 0 and stale captures are cleared
    wr(3'd1, 32'h00);
    tb_oe = 8'hFF; tb_val = 8'h00;
    ticks(5);
    wr(3'd3, 32'hFF);

`ifdef BIDIR_PIO_EDGE_IRQ_EN
    rd(3'd3, rd_val); check("edge_cleared", rd_val, 32'h0);
    wr(3'd2, 32'h01);
    rd(3'd2, rd_val); check("mask_read", rd_val, 32'h01);
    check("irq_idle", {31'h0, irq}, 32'h0);

    // T4: rising edge on pin0 with mask bit0
    tb_val = 8'h01;
    ticks(5);
    rd(3'd3, rd_val); check("edge_pin0", rd_val, 32'h01);
    check("irq_set", {31'h0, irq}, 32'h1);
    wr(3'd3, 32'h01);
    tick();
    check("irq_clr", {31'h0, irq}, 32'h0);
    rd(3'd3, rd_val); check("edge_clr", rd_val, 32'h0);

    // masked edge on pin1 captures without irq
    tb_val = 8'h03;
    ticks(5);
    rd(3'd3, rd_val); check("edge_pin1", rd_val, 32'h02);
    check("irq_masked", {31'h0, irq}, 32'h0);
    wr(3'd3, 32'h02);

    // falling edge is not captured for rising-edge mode
    tb_val = 8'h02;
    ticks(5);
    rd(3'd3, rd_val); check("fall_ignored", rd_val, 32'h0);

    // T5: clear and new rise land on the same edge
    tb_val = 8'h03;
    ticks(5);
    check("irq_pre_race", {31'h0, irq}, 32'h1);
    tb_val = 8'h02;
    ticks(5);
    tb_val = 8'h03;
    ticks(2);
    wr(3'd3, 32'h01);
    check("irq_race0", {31'h0, irq}, 32'h1);
    tick();
    check("irq_race1", {31'h0, irq}, 32'h1);
    rd(3'd3, rd_val); check("edge_race", rd_val, 32'h01);
`else
    wr(3'd2, 32'hFF);
    rd(3'd2, rd_val); check("mask_absent", rd_val, 32'h0);
    tb_val = 8'hFF;
    ticks(5);
    rd(3'd3, rd_val); check("edge_absent", rd_val, 32'h0);
    check("irq_tied", {31'h0, irq}, 32'h0);
    tb_val = 8'h00;
    ticks(5);
`endif

    // Reset releases the pins without a clock edge
    tb_oe = 8'h00;
    wr(3'd0, 32'hA5);
    wr(3'd1, 32'hFF);
    check("pre_rst_pins", {24'h0, pins}, 32'hA5);
    address = 3'd1;
    reset = 1'b1;
    #1;
    tb_oe = 8'hFF; tb_val = 8'hFF;
    #1;
    check("rst_tristate", {24'h0, pins}, 32'hFF);
    check("rst_irq_async", {31'h0, irq}, 32'h0);
    tick();
    check("rst_readdata2", readdata, 32'h0);

    // T6: pins high through reset release give no false edge
    tick();
    reset = 1'b0;
    ticks(8);
    rd(3'd3, rd_val); check("warm_edge", rd_val, 32'h0);
    check("warm_irq", {31'h0, irq}, 32'h0);
    rd(3'd1, rd_val); check("warm_dir", rd_val, 32'h0);
    rd(3'd2, rd_val); check("warm_mask", rd_val, 32'h0);
    rd(3'd0, rd_val); check("warm_pins", rd_val, 32'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
